// File: rtl/dispense_pkg.sv
// Shared types and default timing for the dispense driver.
// Event words, executor states and solenoid selectors.
package dispense_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GAP
    } state_t;

    typedef struct packed {
        logic dis;
        logic rn;
        logic rd;
        logic rtd;
    } event_t;

    typedef enum logic [1:0] {
        SOL_NONE,
        SOL_CAN,
        SOL_NICKEL,
        SOL_DIME
    } sol_sel_t;

    localparam int PULSE_LEN_DEF = 4;
    localparam int GAP_LEN_DEF   = 2;
    localparam int DEPTH_DEF     = 4;

    // Dimes owed by one event: rd is one, rtd is two.
    function automatic logic [1:0] dime_count(input event_t e);
        return {e.rtd, e.rd};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Event FIFO between the capture stage and the executor.
// A full FIFO still accepts a push when a pop frees a slot.
module cmd_fifo
    import dispense_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  event_t din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output logic   last,
    output event_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    event_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_wr;
    logic           do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign last  = (count == CW'(1));
    assign head  = mem[rd_ptr];

    assign do_wr = push && (!full || pop);
    assign do_rd = pop && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; reset flushes everything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/dispense_driver.sv
// Turns dispenser pulses into timed, mutually exclusive
// solenoid firings for the can, nickel and dime actuators.
module dispense_driver
    import dispense_pkg::*;
#(
    parameter int PULSE_LEN = PULSE_LEN_DEF,
    parameter int GAP_LEN   = GAP_LEN_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic dis,
    input  logic rn,
    input  logic rd,
    input  logic rtd,
    output logic sol_can,
    output logic sol_nickel,
    output logic sol_dime,
    output logic busy,
    output logic overflow
);

    localparam int CMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW   = $clog2(CMAX + 1);

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic           can_pend;
    logic           can_n;
    logic           nick_pend;
    logic           nick_n;
    logic [1:0]     dime_cnt;
    logic [1:0]     dime_n;
    logic [2:0]     sol_q;
    logic [2:0]     sol_n;
    logic           busy_q;
    logic           busy_n;
    logic           ovf_q;

    event_t         ev;
    event_t         head;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           last;
    logic           wr_ok;
    logic           take;
    logic           load;
    logic           w_can;
    logic           w_nick;
    logic [1:0]     w_dime;
    sol_sel_t       sel;

    assign ev   = '{dis: dis, rn: rn, rd: rd, rtd: rtd};
    assign push = (ev != '0);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (ev),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .last  (last),
        .head  (head)
    );

    assign wr_ok = push && (!full || pop);

    assign sol_can    = sol_q[2];
    assign sol_nickel = sol_q[1];
    assign sol_dime   = sol_q[0];
    assign busy       = busy_q;
    assign overflow   = ovf_q;

    // Executor next state: pulse/gap timing, item selection, pops.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        can_n   = can_pend;
        nick_n  = nick_pend;
        dime_n  = dime_cnt;
        sol_n   = '0;
        take    = 1'b0;
        load    = 1'b0;
        sel     = SOL_NONE;

        unique case (state)
            IDLE: begin
                if (!empty) begin
                    take = 1'b1;
                    load = 1'b1;
                end
            end
            FIRE: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = CW'(GAP_LEN - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                    sol_n = sol_q;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (can_pend || nick_pend || dime_cnt != '0) begin
                    take = 1'b1;
                end else if (!empty) begin
                    take = 1'b1;
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        pop    = load;
        w_can  = load ? head.dis : can_pend;
        w_nick = load ? head.rn : nick_pend;
        w_dime = load ? dime_count(head) : dime_cnt;

        if (take) begin
            state_n = FIRE;
            cnt_n   = CW'(PULSE_LEN - 1);
            can_n   = w_can;
            nick_n  = w_nick;
            dime_n  = w_dime;
            if (w_can) begin
                sel   = SOL_CAN;
                can_n = 1'b0;
            end else if (w_nick) begin
                sel    = SOL_NICKEL;
                nick_n = 1'b0;
            end else if (w_dime != '0) begin
                sel    = SOL_DIME;
                dime_n = w_dime - 2'd1;
            end
        end

        unique case (sel)
            SOL_CAN:    sol_n = 3'b100;
            SOL_NICKEL: sol_n = 3'b010;
            SOL_DIME:   sol_n = 3'b001;
            SOL_NONE:   sol_n = sol_n;
            default:    sol_n = '0;
        endcase

        busy_n = (state_n != IDLE) || wr_ok
               || (!empty && !(pop && last));
    end

    // State, working register and output flops; reset drops all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            can_pend  <= 1'b0;
            nick_pend <= 1'b0;
            dime_cnt  <= '0;
            sol_q     <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            can_pend  <= can_n;
            nick_pend <= nick_n;
            dime_cnt  <= dime_n;
            sol_q     <= sol_n;
            busy_q    <= busy_n;
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispense_driver.sv
// Directed bench for dispense_driver: vector table plus
// overflow and mid-firing reset sequences.
module tb_dispense_driver;

    logic clk;
    logic reset;
    logic dis;
    logic rn;
    logic rd;
    logic rtd;
    logic sol_can;
    logic sol_nickel;
    logic sol_dime;
    logic busy;
    logic overflow;

    int total;
    int bad;

    typedef struct {
        logic [3:0] ev;
        int         n_can;
        int         n_nick;
        int         n_dime;
    } vec_t;

    vec_t vecs [7];

    dispense_driver #(
        .PULSE_LEN (4),
        .GAP_LEN   (2),
        .DEPTH     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dis        (dis),
        .rn         (rn),
        .rd         (rd),
        .rtd        (rtd),
        .sol_can    (sol_can),
        .sol_nickel (sol_nickel),
        .sol_dime   (sol_dime),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {overflow, busy, sol_can, sol_nickel, sol_dime};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] act,
                       input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // At most one solenoid may be energised in any cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            total++;
            if ((32'(sol_can) + 32'(sol_nickel) + 32'(sol_dime)) > 1) begin
                bad++;
                $display("FAIL onehot: got %b%b%b want at most one",
                         sol_can, sol_nickel, sol_dime);
            end
        end
    end

    initial begin
        logic [2:0] seq [8];
        logic [2:0] es;
        logic       eb;
        logic       prev;
        int         n;
        int         k;
        int         ph;
        int         nr;
        int         rise [8];

        total = 0;
        bad   = 0;
        vecs[0] = '{4'b1000, 1, 0, 0};
        vecs[1] = '{4'b1001, 1, 0, 2};
        vecs[2] = '{4'b0110, 0, 1, 1};
        vecs[3] = '{4'b0010, 0, 0, 1};
        vecs[4] = '{4'b0001, 0, 0, 2};
        vecs[5] = '{4'b1111, 1, 1, 3};
        vecs[6] = '{4'b0101, 0, 1, 2};

        reset = 1'b1;
        {dis, rn, rd, rtd} = 4'b0000;
        #2 reset = 1'b0;
        #1 chk("reset_state", outs(), 5'b00000);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_idle", outs(), 5'b00000);

        for (int v = 0; v < 7; v++) begin
            n = 0;
            for (int i = 0; i < vecs[v].n_can; i++) begin
                seq[n] = 3'b100;
                n++;
            end
            for (int i = 0; i < vecs[v].n_nick; i++) begin
                seq[n] = 3'b010;
                n++;
            end
            for (int i = 0; i < vecs[v].n_dime; i++) begin
                seq[n] = 3'b001;
                n++;
            end
            {dis, rn, rd, rtd} = vecs[v].ev;
            tick();
            {dis, rn, rd, rtd} = 4'b0000;
            chk($sformatf("vec%0d_c0", v), outs(), 5'b01000);
            for (int c = 1; c <= 6 * n + 2; c++) begin
                tick();
                k  = (c - 1) / 6;
                ph = (c - 1) % 6;
                es = (k < n && ph < 4) ? seq[k] : 3'b000;
                eb = (c <= 6 * n);
                chk($sformatf("vec%0d_c%0d", v, c), outs(), {1'b0, eb, es});
            end
            tick();
            tick();
        end

        nr   = 0;
        prev = 1'b0;
        for (int c = 0; c <= 80; c++) begin
            dis = (c <= 5);
            tick();
            if (sol_can && !prev && nr < 8) begin
                rise[nr] = c;
                nr++;
            end
            prev = sol_can;
            if (c == 4) chk("ovf_before_drop", {4'b0, overflow}, 5'b00000);
            if (c == 6) chk("ovf_after_drop", {4'b0, overflow}, 5'b00001);
        end
        dis = 1'b0;
        chk_int("ovf_can_pulses", nr, 5);
        for (int i = 0; i < 5; i++) begin
            chk_int($sformatf("ovf_rise%0d", i), rise[i], 1 + 6 * i);
        end
        chk("ovf_sticky_idle", outs(), 5'b10000);

        reset = 1'b0;
        #1 chk("ovf_cleared", outs(), 5'b00000);
        tick();
        reset = 1'b1;
        tick();

        for (int c = 0; c < 3; c++) begin
            dis = 1'b1;
            tick();
        end
        dis = 1'b0;
        tick();
        chk("mid_fire_can", outs(), 5'b01100);
        #2 reset = 1'b0;
        #1 chk("mid_fire_reset", outs(), 5'b00000);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk($sformatf("no_replay_c%0d", c), outs(), 5'b00000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
